// File: rtl/gesture_command_shaper.sv
// Shapes tracker hand offsets into slew-limited roll/pitch/hover DAC codes,
// with an arm gate and a sample-timeout failsafe.
module gesture_command_shaper #(
  parameter int TICK_CYCLES   = 65536,
  parameter int SLEW_STEP     = 4,
  parameter int DEADBAND      = 6,
  parameter int TIMEOUT_TICKS = 8,
  parameter int HOVER_SAFE    = 96
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       arm,
  input  logic       sample_valid,
  input  logic [8:0] hand_x,
  input  logic [8:0] hand_y,
  input  logic [8:0] hand_z,
  output logic [7:0] roll,
  output logic [7:0] pitch,
  output logic [7:0] hover,
  output logic [1:0] state,
  output logic       failsafe
);

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_CYCLES - 1);
  localparam logic [8:0]        STEP_9      = 9'(SLEW_STEP);
  localparam logic [7:0]        STEP_8      = 8'(SLEW_STEP);
  localparam logic [9:0]        DEADBAND_10 = 10'(DEADBAND);
  localparam logic [3:0]        TIMEOUT_4   = 4'(TIMEOUT_TICKS);
  // Axis index 0=roll, 1=pitch, 2=hover.
  localparam logic [2:0][7:0]   NEUTRAL     = '{8'd0, 8'd128, 8'd128};
  localparam logic [2:0][7:0]   SAFE        = '{8'(HOVER_SAFE), 8'd128, 8'd128};

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_FAILSAFE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [TICK_W-1:0]  tick_cnt_reg;
  logic               tick;
  logic [3:0]         timeout_reg, timeout_next, timeout_inc;
  logic [2:0][7:0]    target_reg, target_next;
  logic [2:0][7:0]    out_reg, out_next;
  logic [2:0][7:0]    mapped, slewed, eff_target;
  logic [2:0][8:0]    hand_off;
  logic               failsafe_reg;

  assign hand_off    = {hand_z, hand_y, hand_x};
  assign tick        = (tick_cnt_reg == TICK_LAST);
  assign eff_target  = (state_reg == ST_FAILSAFE) ? SAFE : target_reg;
  assign timeout_inc = (timeout_reg == 4'hF) ? 4'hF : timeout_reg + 4'd1;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_axis
      logic [9:0] off_ext, off_mag;
      logic [8:0] sum, diff, diff_mag;

      // Magnitude at 10 bits so -256 does not wrap back to a small value.
      assign off_ext    = {hand_off[gi][8], hand_off[gi]};
      assign off_mag    = off_ext[9] ? (10'd0 - off_ext) : off_ext;
      assign sum        = 9'd128 + {hand_off[gi][8], hand_off[gi][8:1]};
      assign mapped[gi] = (off_mag < DEADBAND_10) ? 8'd128 : sum[7:0];

      assign diff       = {1'b0, eff_target[gi]} - {1'b0, out_reg[gi]};
      assign diff_mag   = diff[8] ? (9'd0 - diff) : diff;
      assign slewed[gi] = (diff_mag <= STEP_9) ? eff_target[gi] :
                          diff[8] ? (out_reg[gi] - STEP_8) : (out_reg[gi] + STEP_8);
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    target_next  = target_reg;
    out_next     = out_reg;
    timeout_next = timeout_reg;
    if (!arm) begin
      state_next   = ST_DISARMED;
      target_next  = NEUTRAL;
      out_next     = NEUTRAL;
      timeout_next = 4'd0;
    end else begin
      case (state_reg)
        ST_DISARMED: begin
          state_next   = ST_ACTIVE;
          target_next  = NEUTRAL;
          out_next     = NEUTRAL;
          timeout_next = 4'd0;
        end
        ST_ACTIVE, ST_FAILSAFE: begin
          if (tick) out_next = slewed;
          // A coincident sample wins over the timeout advance.
          if (sample_valid) begin
            target_next  = mapped;
            timeout_next = 4'd0;
            state_next   = ST_ACTIVE;
          end else if (tick) begin
            timeout_next = timeout_inc;
            if (state_reg == ST_ACTIVE && timeout_inc >= TIMEOUT_4)
              state_next = ST_FAILSAFE;
          end
        end
        default: state_next = ST_DISARMED;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg    <= ST_DISARMED;
      tick_cnt_reg <= '0;
      timeout_reg  <= 4'd0;
      target_reg   <= NEUTRAL;
      out_reg      <= NEUTRAL;
      failsafe_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
      timeout_reg  <= timeout_next;
      target_reg   <= target_next;
      out_reg      <= out_next;
      failsafe_reg <= (state_next == ST_FAILSAFE);
    end
  end

  assign roll     = out_reg[0];
  assign pitch    = out_reg[1];
  assign hover    = out_reg[2];
  assign state    = state_reg;
  assign failsafe = failsafe_reg;

endmodule

// File: tb/tb_gesture_command_shaper.sv
// Checks gesture_command_shaper against an integer reference model each cycle,
// plus hand-computed expectations in directed scenarios and random stimulus.
module tb_gesture_command_shaper;

  logic       clock = 1'b0;
  logic       reset_n, arm, sample_valid;
  logic [8:0] hand_x, hand_y, hand_z;
  logic [7:0] roll, pitch, hover;
  logic [1:0] state;
  logic       failsafe;

  int checks = 0;
  int errors = 0;

  gesture_command_shaper #(
    .TICK_CYCLES(16), .SLEW_STEP(4), .DEADBAND(6), .TIMEOUT_TICKS(8), .HOVER_SAFE(96)
  ) dut (
    .clock(clock), .reset_n(reset_n), .arm(arm), .sample_valid(sample_valid),
    .hand_x(hand_x), .hand_y(hand_y), .hand_z(hand_z),
    .roll(roll), .pitch(pitch), .hover(hover), .state(state), .failsafe(failsafe)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_cnt = 0, m_state = 0, m_to = 0;
  int m_out[3], m_tgt[3];
  bit m_ok = 0, m_tick;

  function automatic int neutral(input int i);
    return (i == 2) ? 0 : 128;
  endfunction
  function automatic int safe_tgt(input int i);
    return (i == 2) ? 96 : 128;
  endfunction
  function automatic int map_off(input int off);
    int a;
    a = (off < 0) ? -off : off;
    if (a < 6) return 128;
    return 128 + (off >>> 1);
  endfunction
  function automatic int slew(input int cur, input int tgt);
    int d;
    d = tgt - cur;
    if (d <= 4 && d >= -4) return tgt;
    return (d > 0) ? cur + 4 : cur - 4;
  endfunction

  always @(posedge clock) begin
    if (!reset_n) begin
      m_ok = 1; m_state = 0; m_to = 0; m_cnt = 0;
      for (int i = 0; i < 3; i++) begin m_out[i] = neutral(i); m_tgt[i] = neutral(i); end
    end else if (m_ok) begin
      m_tick = (m_cnt == 15);
      m_cnt  = (m_cnt + 1) % 16;
      if (!arm) begin
        m_state = 0; m_to = 0;
        for (int i = 0; i < 3; i++) begin m_out[i] = neutral(i); m_tgt[i] = neutral(i); end
      end else if (m_state == 0) begin
        m_state = 1; m_to = 0;
        for (int i = 0; i < 3; i++) m_tgt[i] = neutral(i);
      end else begin
        if (m_tick)
          for (int i = 0; i < 3; i++)
            m_out[i] = slew(m_out[i], (m_state == 2) ? safe_tgt(i) : m_tgt[i]);
        if (sample_valid) begin
          m_tgt[0] = map_off($signed(hand_x));
          m_tgt[1] = map_off($signed(hand_y));
          m_tgt[2] = map_off($signed(hand_z));
          m_to = 0; m_state = 1;
        end else if (m_tick) begin
          m_to = (m_to < 15) ? m_to + 1 : 15;
          if (m_state == 1 && m_to >= 8) m_state = 2;
        end
      end
    end
    #1;
    if (m_ok) begin
      chk("model_roll", roll, m_out[0]);
      chk("model_pitch", pitch, m_out[1]);
      chk("model_hover", hover, m_out[2]);
      chk("model_state", state, m_state);
      chk("model_failsafe", failsafe, (m_state == 2) ? 1 : 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_sample();
    if (m_cnt == 15) @(negedge clock);
    sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
  endtask

  task automatic run_ticks(input int n, input bit refresh);
    int guard;
    for (int k = 0; k < n; k++) begin
      if (refresh) pulse_sample();
      guard = 0;
      while (m_cnt != 15 && guard < 40) begin @(negedge clock); guard++; end
      if (guard >= 40) chk("tick_wait_timeout", guard, 0);
      @(negedge clock);
    end
  endtask

  task automatic expect_out(input string tag, input int r, input int p, input int h,
                            input int s, input int f);
    chk({tag, "_roll"}, roll, r);
    chk({tag, "_pitch"}, pitch, p);
    chk({tag, "_hover"}, hover, h);
    chk({tag, "_state"}, state, s);
    chk({tag, "_failsafe"}, failsafe, f);
  endtask

  int quiet;

  initial begin
    reset_n = 1'b0; arm = 1'b1; sample_valid = 1'b0;
    hand_x = '0; hand_y = '0; hand_z = '0;
    repeat (3) @(negedge clock);
    $display("scenario reset with arm held");
    expect_out("reset", 128, 128, 0, 0, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("reset_release_state", state, 1);

    $display("scenario hand_x=+100 slew");
    hand_x = 9'd100;
    run_ticks(1, 1);  chk("x100_tick1", roll, 132);
    run_ticks(10, 1); chk("x100_tick11", roll, 172);
    run_ticks(1, 1);  chk("x100_tick12", roll, 176);
    run_ticks(1, 1);  chk("x100_tick13", roll, 178);
    run_ticks(2, 1);  chk("x100_hold", roll, 178);
    chk("x100_pitch", pitch, 128);

    $display("scenario deadband and extremes");
    hand_x = 9'h100; hand_y = 9'd5; hand_z = 9'h1FB;
    run_ticks(50, 1);
    chk("xm256_roll", roll, 0); chk("y5_pitch", pitch, 128); chk("zm5_hover", hover, 128);
    hand_x = 9'd255;
    run_ticks(63, 1); chk("x255_tick63", roll, 252);
    run_ticks(1, 1);  chk("x255_tick64", roll, 255);

    $display("scenario arm drop, re-arm, timeout to failsafe");
    arm = 1'b0; @(negedge clock);
    expect_out("disarm", 128, 128, 0, 0, 0);
    arm = 1'b1; @(negedge clock);
    chk("rearm_state", state, 1);
    hand_x = '0; hand_y = '0; hand_z = '0;
    run_ticks(7, 0);  expect_out("timeout7", 128, 128, 0, 1, 0);
    run_ticks(1, 0);  expect_out("timeout8", 128, 128, 0, 2, 1);
    run_ticks(23, 0); chk("fs_hover23", hover, 92);
    run_ticks(1, 0);  chk("fs_hover24", hover, 96);
    pulse_sample();
    chk("fs_exit_state", state, 1); chk("fs_exit_failsafe", failsafe, 0);

    $display("scenario arm drop mid-slew");
    hand_x = 9'd44;
    run_ticks(5, 1); chk("x44_tick5", roll, 148);
    run_ticks(1, 1); chk("x44_tick6", roll, 150);
    arm = 1'b0; @(negedge clock);
    expect_out("midslew_disarm", 128, 128, 0, 0, 0);
    hand_x = 9'd100;
    run_ticks(2, 1);
    expect_out("disarmed_ignore", 128, 128, 0, 0, 0);

    $display("scenario arm rise with coincident sample");
    arm = 1'b1; sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
    chk("armrise_state", state, 1);
    run_ticks(1, 0);
    chk("armrise_roll", roll, 128);

    $display("scenario sample coincident with tick");
    hand_x = 9'd24;
    pulse_sample();
    begin
      int guard = 0;
      while (m_cnt != 15 && guard < 40) begin @(negedge clock); guard++; end
    end
    hand_x = 9'd144; sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
    chk("coincide_roll", roll, 132);
    run_ticks(1, 0); chk("coincide_next", roll, 136);
    run_ticks(6, 0); chk("coincide_to7_state", state, 1);
    run_ticks(1, 0); chk("coincide_to8_state", state, 2);

    $display("scenario random traffic");
    quiet = 0;
    for (int c = 0; c < 4000; c++) begin
      reset_n = ($urandom_range(0, 249) != 0);
      if ($urandom_range(0, 399) == 0) arm = ~arm;
      if (quiet > 0) begin
        sample_valid = 1'b0;
        quiet--;
      end else begin
        sample_valid = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 299) == 0) quiet = $urandom_range(100, 300);
      end
      if ($urandom_range(0, 1) == 0) begin
        hand_x = 9'($urandom_range(0, 511));
        hand_y = 9'($urandom_range(0, 511));
        hand_z = 9'($urandom_range(0, 511));
      end else begin
        hand_x = 9'($signed($urandom_range(0, 16)) - 8);
        hand_y = 9'($signed($urandom_range(0, 16)) - 8);
        hand_z = 9'($signed($urandom_range(0, 16)) - 8);
      end
      if (sample_valid)
        $display("sample c=%0d arm=%0d rst_n=%0d x=%0d y=%0d z=%0d", c, arm, reset_n,
                 $signed(hand_x), $signed(hand_y), $signed(hand_z));
      @(negedge clock);
    end
    sample_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
